// File: rtl/start_pic_disp.sv
// Start-screen image requester: issues one ROM read per pixel inside a centred window,
// realigns ROM data with delayed syncs/DE, and flags frames whose read count is wrong.
// Optional START_DISP_BORDER_EN adds a BORDER_COLOR ring directly around the window.

// frame_st | meaning
// ---------+-----------------------------------------------------------
// ST_FIRST | first frame after reset, count is not checked at its end
// ST_CHECK | every later frame, count compared at the next vsync edge
module start_pic_disp #(
  parameter int         IMG_W    = 200,
  parameter int         IMG_H    = 200,
  parameter int         IMG_X0   = 220,
  parameter int         IMG_Y0   = 140,
  parameter int         RD_LAT   = 2,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter logic       VS_ACT   = 1'b0
`ifdef START_DISP_BORDER_EN
  ,
  parameter logic [7:0] BORDER_COLOR = 8'hFF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_de,
  input  logic       pix_hs,
  input  logic       pix_vs,
  output logic       start_rd_en,
  input  logic [7:0] start_data,
  output logic [7:0] vga_rgb,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic       frame_err
);

  localparam logic [10:0] X_LO     = 11'(IMG_X0);
  localparam logic [10:0] X_HI     = 11'(IMG_X0 + IMG_W);
  localparam logic [10:0] Y_LO     = 11'(IMG_Y0);
  localparam logic [10:0] Y_HI     = 11'(IMG_Y0 + IMG_H);
  localparam logic [15:0] FRAME_RD = 16'(IMG_W * IMG_H);
  localparam logic        IDLE     = ~VS_ACT;

  typedef enum logic {ST_FIRST, ST_CHECK} frame_st_t;

  logic [10:0] x_ext, y_ext;
  logic        in_win;
  logic        ring;

  assign x_ext  = {1'b0, pix_x};
  assign y_ext  = {1'b0, pix_y};
  assign in_win = pix_de && (x_ext >= X_LO) && (x_ext < X_HI) &&
                  (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign start_rd_en = in_win;

`ifdef START_DISP_BORDER_EN
  // +1 on the pixel side keeps the lower ring edge free of underflow when X0/Y0 = 0
  assign ring = pix_de && !in_win &&
                (11'(x_ext + 11'd1) >= X_LO) && (x_ext <= X_HI) &&
                (11'(y_ext + 11'd1) >= Y_LO) && (y_ext <= Y_HI);
`else
  assign ring = 1'b0;
`endif

  logic win_d [RD_LAT];
  logic brd_d [RD_LAT];
  logic de_d  [RD_LAT];
  logic hs_d  [RD_LAT];
  logic vs_d  [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        win_d[i] <= 1'b0;
        brd_d[i] <= 1'b0;
        de_d[i]  <= 1'b0;
        hs_d[i]  <= IDLE;
        vs_d[i]  <= IDLE;
      end
    end else begin
      win_d[0] <= in_win;
      brd_d[0] <= ring;
      de_d[0]  <= pix_de;
      hs_d[0]  <= pix_hs;
      vs_d[0]  <= pix_vs;
      for (int i = 1; i < RD_LAT; i++) begin
        win_d[i] <= win_d[i-1];
        brd_d[i] <= brd_d[i-1];
        de_d[i]  <= de_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

  logic [7:0] rgb_nxt;

  always_comb begin
    rgb_nxt = BG_COLOR;
    if (!de_d[RD_LAT-1])
      rgb_nxt = 8'h00;
    else if (win_d[RD_LAT-1])
      rgb_nxt = start_data;
    else if (brd_d[RD_LAT-1])
`ifdef START_DISP_BORDER_EN
      rgb_nxt = BORDER_COLOR;
`else
      rgb_nxt = BG_COLOR;
`endif
  end

  // Output stage samples on the cycle start_data for the oldest stage is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb <= 8'h00;
      vga_de  <= 1'b0;
      vga_hs  <= IDLE;
      vga_vs  <= IDLE;
    end else begin
      vga_rgb <= rgb_nxt;
      vga_de  <= de_d[RD_LAT-1];
      vga_hs  <= hs_d[RD_LAT-1];
      vga_vs  <= vs_d[RD_LAT-1];
    end
  end

  logic        vs_q;
  logic        vs_edge;
  logic [15:0] rd_cnt;
  frame_st_t   frame_st, frame_st_nxt;
  logic        err_set;

  assign vs_edge = (pix_vs == VS_ACT) && (vs_q != VS_ACT);

  always_comb begin
    frame_st_nxt = frame_st;
    err_set      = 1'b0;
    case (frame_st)
      ST_FIRST: if (vs_edge) frame_st_nxt = ST_CHECK;
      ST_CHECK: err_set = vs_edge && (rd_cnt != FRAME_RD);
      default:  frame_st_nxt = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_st  <= ST_FIRST;
      vs_q      <= IDLE;
      rd_cnt    <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      frame_st <= frame_st_nxt;
      vs_q     <= pix_vs;
      if (err_set)
        frame_err <= 1'b1;
      // a read on the boundary cycle belongs to the new frame
      if (vs_edge)
        rd_cnt <= {15'd0, in_win};
      else if (in_win && (rd_cnt != 16'hFFFF))
        rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_start_pic_disp.sv
// Bench for start_pic_disp on a shrunken raster (48x20 active) and a 16x8 window,
// with a ROM model that returns the low byte of its frame-wrapping read address.
module tb_start_pic_disp;

  localparam int         IMG_W  = 16;
  localparam int         IMG_H  = 8;
  localparam int         IMG_X0 = 20;
  localparam int         IMG_Y0 = 6;
  localparam int         RD_LAT = 2;
  localparam logic [7:0] BG     = 8'h25;
  localparam int         H_ACT  = 48;
  localparam int         H_TOT  = 56;
  localparam int         V_ACT  = 20;
  localparam int         V_TOT  = 24;
  localparam int         NPIX   = IMG_W * IMG_H;
`ifdef START_DISP_BORDER_EN
  localparam logic [7:0] RING   = 8'hE0;
`else
  localparam logic [7:0] RING   = BG;
`endif

  logic       clk, rst_n;
  logic [9:0] pix_x, pix_y;
  logic       pix_de, pix_hs, pix_vs;
  logic       start_rd_en;
  logic [7:0] start_data;
  logic [7:0] vga_rgb;
  logic       vga_hs, vga_vs, vga_de, frame_err;

  start_pic_disp #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
    .RD_LAT(RD_LAT), .BG_COLOR(BG), .VS_ACT(1'b0)
`ifdef START_DISP_BORDER_EN
    , .BORDER_COLOR(8'hE0)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .start_rd_en(start_rd_en),
    .start_data(start_data), .vga_rgb(vga_rgb), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_de(vga_de), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data for a read is valid two cycles after its rd_en cycle
  logic [15:0] rom_addr;
  logic [7:0]  rom_q1, rom_q2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= 16'd0;
      rom_q1   <= 8'h00;
      rom_q2   <= 8'h00;
    end else begin
      rom_q2 <= rom_q1;
      if (start_rd_en) begin
        rom_q1   <= rom_addr[7:0];
        rom_addr <= (rom_addr == 16'(NPIX - 1)) ? 16'd0 : rom_addr + 16'd1;
      end
    end
  end
  assign start_data = rom_q2;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       de;
  } out_t;

  localparam out_t IDLE_O = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, de: 1'b0};

  out_t hist [3];
  int   n_vec, n_err;
  int   exp_addr;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // one cycle: check outputs due from three cycles ago, then drive the new pixel
  task automatic apply(input int x, input int y, input logic de, input logic hs,
                       input logic vs, input logic exp_rd, input out_t exp_o,
                       input string tag);
    out_t got;
    @(negedge clk);
    got = {vga_rgb, vga_hs, vga_vs, vga_de};
    n_vec++;
    if (got !== hist[2]) begin
      n_err++;
      $display("FAIL vga_out(%s): rgb/hs/vs/de got %h/%b/%b/%b want %h/%b/%b/%b", tag,
               got.rgb, got.hs, got.vs, got.de,
               hist[2].rgb, hist[2].hs, hist[2].vs, hist[2].de);
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = exp_o;
    pix_x  = 10'(x);
    pix_y  = 10'(y);
    pix_de = de;
    pix_hs = hs;
    pix_vs = vs;
    #1;
    check({"rd_en(", tag, ")"}, int'(start_rd_en), int'(exp_rd));
  endtask

  task automatic model_cycle(input int x, input int y, input logic de,
                             input logic hs, input logic vs);
    logic w, r;
    out_t o;
    w = de && x >= IMG_X0 && x < IMG_X0 + IMG_W && y >= IMG_Y0 && y < IMG_Y0 + IMG_H;
    r = de && !w && x >= IMG_X0 - 1 && x <= IMG_X0 + IMG_W &&
        y >= IMG_Y0 - 1 && y <= IMG_Y0 + IMG_H;
    o.hs  = hs;
    o.vs  = vs;
    o.de  = de;
    o.rgb = !de ? 8'h00 : w ? 8'(exp_addr) : r ? RING : BG;
    apply(x, y, de, hs, vs, w, o, "frame");
    if (w) exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n  = 1'b0;
    pix_de = 1'b0;
    pix_hs = 1'b1;
    pix_vs = 1'b1;
    pix_x  = 10'd0;
    pix_y  = 10'd0;
    #1;
    check({"rst_rgb(", tag, ")"}, int'(vga_rgb), 0);
    check({"rst_syncs_de(", tag, ")"}, int'({vga_hs, vga_vs, vga_de}), 3'b110);
    check({"rst_frame_err(", tag, ")"}, int'(frame_err), 0);
    hist[0] = IDLE_O;
    hist[1] = IDLE_O;
    hist[2] = IDLE_O;
    exp_addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // raster from (0,0); err_b/err_a are frame_err just before/after the vsync edge
  task automatic run_frame(input int stop_row, input int drop_x, input int drop_y,
                           output logic err_b, output logic err_a, output int nrd);
    logic de, hs, vs, after_edge;
    nrd = 0;
    err_b = 1'b0;
    err_a = 1'b0;
    after_edge = 1'b0;
    for (int vc = 0; vc < V_TOT; vc++) begin
      if (vc == stop_row) return;
      for (int hc = 0; hc < H_TOT; hc++) begin
        de = (hc < H_ACT) && (vc < V_ACT) && !(hc == drop_x && vc == drop_y);
        hs = !(hc >= H_ACT + 2 && hc < H_ACT + 5);
        vs = !(vc >= V_ACT + 1 && vc < V_ACT + 3);
        model_cycle(hc, vc, de, hs, vs);
        if (start_rd_en) nrd++;
        if (after_edge) begin
          err_a = frame_err;
          after_edge = 1'b0;
        end
        if (vc == V_ACT + 1 && hc == 0) begin
          err_b = frame_err;
          after_edge = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    int         x, y;
    logic       de, hs, vs;
    logic       rd;
    logic       ring;
    logic [7:0] rgb;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic eb, ea;
    int   nrd;
    out_t o;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    pix_de = 1'b0; pix_hs = 1'b1; pix_vs = 1'b1;

    //            x   y   de    hs    vs    rd    ring  rgb
    vecs[0]  = '{19,  6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BG};
    vecs[1]  = '{20,  6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{21,  6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[3]  = '{35,  6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02};
    vecs[4]  = '{36,  6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BG};
    vecs[5]  = '{25,  6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{20,  5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BG};
    vecs[7]  = '{20, 14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BG};
    vecs[8]  = '{35, 13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[9]  = '{19,  5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BG};
    vecs[10] = '{37,  6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BG};
    vecs[11] = '{20, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BG};
    vecs[12] = '{47, 19, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BG};
    vecs[13] = '{30, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    do_reset("init");

    for (int i = 0; i < 14; i++) begin
      o.rgb = vecs[i].ring ? RING : vecs[i].rgb;
      o.hs  = vecs[i].hs;
      o.vs  = vecs[i].vs;
      o.de  = vecs[i].de;
      apply(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].hs, vecs[i].vs,
            vecs[i].rd, o, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 4; i++) apply(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, IDLE_O, "flush");

    // two clean frames after reset
    do_reset("frames");
    run_frame(V_TOT, -1, -1, eb, ea, nrd);
    check("f1_reads", nrd, NPIX);
    check("f1_err_after", int'(ea), 0);
    run_frame(V_TOT, -1, -1, eb, ea, nrd);
    check("f2_reads", nrd, NPIX);
    check("f2_err_after", int'(ea), 0);

    // one dropped in-window pixel, flagged at that frame's closing vsync edge
    run_frame(V_TOT, 25, 9, eb, ea, nrd);
    check("f3_reads", nrd, NPIX - 1);
    check("f3_err_before", int'(eb), 0);
    check("f3_err_after", int'(ea), 1);
    run_frame(V_TOT, -1, -1, eb, ea, nrd);
    check("f4_reads", nrd, NPIX);
    check("f4_err_sticky", int'(ea), 1);
    check("f4_err_before", int'(eb), 1);

    // reset mid-frame, then normal frames
    run_frame(9, -1, -1, eb, ea, nrd);
    do_reset("midframe");
    run_frame(V_TOT, -1, -1, eb, ea, nrd);
    check("r1_reads", nrd, NPIX);
    check("r1_err_after", int'(ea), 0);
    run_frame(V_TOT, -1, -1, eb, ea, nrd);
    check("r2_reads", nrd, NPIX);
    check("r2_err_after", int'(ea), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
